// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor controller: FSM state encoding
// and the sequencing counter width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Guard against a zero-width counter for the smallest legal width.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Host handshake/operand bundle for serial_subtractor_ctrl.
// SERIAL_SUB_OVERFLOW_EN adds the signed overflow result bit.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrowIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrowOut;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    modport master (
        output start, a, b, borrowIn,
        input  busy, done, difference, borrowOut
`ifdef SERIAL_SUB_OVERFLOW_EN
        , input overflow
`endif
    );

    modport slave (
        input  start, a, b, borrowIn,
        output busy, done, difference, borrowOut
`ifdef SERIAL_SUB_OVERFLOW_EN
        , output overflow
`endif
    );

endinterface

// File: rtl/serial_subtractor_ctrl_fullsub.sv
// One-bit full subtractor cell: difference = a - b - borrowIn.
module fullSubtractor (
    output logic difference,
    output logic borrowOut,
    input  logic a,
    input  logic b,
    input  logic borrowIn
);

    assign difference = a ^ b ^ borrowIn;
    assign borrowOut  = (~a & b) | (~(a ^ b) & borrowIn);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller, LSB first through one fullSubtractor.
// Optional SERIAL_SUB_OVERFLOW_EN adds a registered signed-overflow output.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_subtractor_ctrl_if.slave bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CW-1:0]    count;
    logic             borrow;
    logic             busy_r;
    logic             done_r;
    logic             bout_r;
    logic             cell_d;
    logic             cell_b;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_r;
`endif

    fullSubtractor u_cell (
        .difference (cell_d),
        .borrowOut  (cell_b),
        .a          (a_reg[0]),
        .b          (b_reg[0]),
        .borrowIn   (borrow)
    );

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.difference = diff_reg;
    assign bus.borrowOut  = bout_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign bus.overflow   = ovf_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            count    <= '0;
            borrow   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            bout_r   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.a;
                        b_reg  <= bus.b;
                        borrow <= bus.borrowIn;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    diff_reg <= {cell_d, diff_reg[WIDTH-1:1]};
                    a_reg    <= a_reg >> 1;
                    b_reg    <= b_reg >> 1;
                    borrow   <= cell_b;
                    // Result flags are latched on the MSB edge so they stay stable
                    // through the next operation's SHIFT phase.
                    if (count == LAST) begin
                        bout_r <= cell_b;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        ovf_r  <= borrow ^ cell_b;
`endif
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8), random ops vs. arithmetic model.
// Overflow checks are active when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic void ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                    output logic [7:0] d, output logic bo, output logic ov);
        int r;
        int s;
        r  = int'(a) - int'(b) - int'(bin);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d  = 8'(r);
        bo = (r < 0);
        ov = (s > 127) || (s < -128);
    endfunction

    // Issues one start and waits (bounded) for done; called at posedge+1 with DUT idle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic busy1, output int cyc, output logic [7:0] d,
                          output logic bo, output logic ov, output logic dn_after);
        bus.a = a; bus.b = b; bus.borrowIn = bin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.borrowIn = 1'($urandom);
        busy1 = bus.busy;
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        d  = bus.difference;
        bo = bus.borrowOut;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ov = bus.overflow;
`else
        ov = 1'b0;
`endif
        @(posedge clk); #1;
        dn_after = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrowIn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
        total++; if (bus.difference !== 8'h00) $display("FAIL reset_diff got %h want 00", bus.difference); else passed++;
        total++; if (bus.borrowOut !== 1'b0) $display("FAIL reset_bout got %b want 0", bus.borrowOut); else passed++;
`ifdef SERIAL_SUB_OVERFLOW_EN
        total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.overflow); else passed++;
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic busy1, bo, ov, dn;
        logic [7:0] d;
        int cyc;
        run_op(8'h05, 8'h03, 1'b0, busy1, cyc, d, bo, ov, dn);
        total++; if (busy1 !== 1'b1) $display("FAIL basic_busy got %b want 1", busy1); else passed++;
        total++; if (cyc != W) $display("FAIL basic_latency got %0d want %0d", cyc, W); else passed++;
        total++; if (d !== 8'h02) $display("FAIL basic_diff got %h want 02", d); else passed++;
        total++; if (bo !== 1'b0) $display("FAIL basic_bout got %b want 0", bo); else passed++;
        total++; if (dn !== 1'b0) $display("FAIL basic_done_width got %b want 0", dn); else passed++;
        total++; if (bus.difference !== 8'h02) $display("FAIL basic_hold got %h want 02", bus.difference); else passed++;
    endtask

    task automatic test_borrow();
        logic busy1, bo, ov, dn;
        logic [7:0] d;
        int cyc;
        run_op(8'h03, 8'h05, 1'b0, busy1, cyc, d, bo, ov, dn);
        total++; if (d !== 8'hFE) $display("FAIL borrow1_diff got %h want fe", d); else passed++;
        total++; if (bo !== 1'b1) $display("FAIL borrow1_bout got %b want 1", bo); else passed++;
        run_op(8'h00, 8'h00, 1'b1, busy1, cyc, d, bo, ov, dn);
        total++; if (d !== 8'hFF) $display("FAIL borrow2_diff got %h want ff", d); else passed++;
        total++; if (bo !== 1'b1) $display("FAIL borrow2_bout got %b want 1", bo); else passed++;
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        logic [7:0] d = '0;
        bus.a = 8'h10; bus.b = 8'h01; bus.borrowIn = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.a = 8'hFF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done) begin pulses++; d = bus.difference; end
            @(posedge clk); #1;
        end
        total++; if (pulses != 1) $display("FAIL ignore_pulses got %0d want 1", pulses); else passed++;
        total++; if (d !== 8'h0F) $display("FAIL ignore_diff got %h want 0f", d); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL ignore_not_queued got busy=%b want 0", bus.busy); else passed++;
    endtask

    task automatic test_rst_mid();
        logic busy1, bo, ov, dn;
        logic [7:0] d;
        int cyc;
        int pulses = 0;
        bus.a = 8'h3C; bus.b = 8'h11; bus.borrowIn = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL rstmid_done got %b want 0", bus.done); else passed++;
        total++; if (bus.difference !== 8'h00) $display("FAIL rstmid_diff got %h want 00", bus.difference); else passed++;
        total++; if (bus.borrowOut !== 1'b0) $display("FAIL rstmid_bout got %b want 0", bus.borrowOut); else passed++;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        total++; if (pulses != 0) $display("FAIL rstmid_no_done got %0d want 0", pulses); else passed++;
        run_op(8'hAA, 8'h55, 1'b0, busy1, cyc, d, bo, ov, dn);
        total++; if (d !== 8'h55) $display("FAIL rstmid_fresh_diff got %h want 55", d); else passed++;
        total++; if (bo !== 1'b0) $display("FAIL rstmid_fresh_bout got %b want 0", bo); else passed++;
    endtask

    task automatic test_back_to_back();
        logic busy1, bo, ov, dn;
        logic [7:0] d;
        int cyc;
        int last = -1;
        int pulses = 0;
        int idle_wait = 0;
        bus.a = 8'h80; bus.b = 8'h01; bus.borrowIn = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                pulses++;
                total++; if (bus.difference !== 8'h7F) $display("FAIL b2b_diff got %h want 7f", bus.difference); else passed++;
`ifdef SERIAL_SUB_OVERFLOW_EN
                total++; if (bus.overflow !== 1'b1) $display("FAIL b2b_ovf got %b want 1", bus.overflow); else passed++;
`endif
                if (last >= 0) begin
                    total++; if (i - last != W + 2) $display("FAIL b2b_period got %0d want %0d", i - last, W + 2); else passed++;
                end
                last = i;
            end
        end
        bus.start = 1'b0;
        total++; if (pulses != 3) $display("FAIL b2b_pulses got %0d want 3", pulses); else passed++;
        while (bus.busy && idle_wait < 20) begin @(posedge clk); #1; idle_wait++; end
        total++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle_timeout got busy=%b want 0", bus.busy); else passed++;
        run_op(8'h7F, 8'h01, 1'b0, busy1, cyc, d, bo, ov, dn);
        total++; if (d !== 8'h7E) $display("FAIL b2b_7f_diff got %h want 7e", d); else passed++;
`ifdef SERIAL_SUB_OVERFLOW_EN
        total++; if (ov !== 1'b0) $display("FAIL b2b_7f_ovf got %b want 0", ov); else passed++;
`endif
    endtask

    task automatic test_random();
        logic busy1, bo, ov, dn, ebo, eov, bin;
        logic [7:0] d, ed, a, b;
        int cyc;
        for (int n = 0; n < 300; n++) begin
            case (n)
                0: begin a = 8'h00; b = 8'h00; bin = 1'b0; end
                1: begin a = 8'hFF; b = 8'hFF; bin = 1'b1; end
                2: begin a = 8'h00; b = 8'hFF; bin = 1'b1; end
                3: begin a = 8'hFF; b = 8'h00; bin = 1'b0; end
                4: begin a = 8'h80; b = 8'h7F; bin = 1'b1; end
                default: begin a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); end
            endcase
            ref_sub(a, b, bin, ed, ebo, eov);
            run_op(a, b, bin, busy1, cyc, d, bo, ov, dn);
            total++;
            if (cyc != W || d !== ed || bo !== ebo)
                $display("FAIL rand_op a=%h b=%h bin=%b got diff=%h bout=%b lat=%0d want diff=%h bout=%b lat=%0d",
                         a, b, bin, d, bo, cyc, ed, ebo, W);
            else passed++;
`ifdef SERIAL_SUB_OVERFLOW_EN
            total++; if (ov !== eov) $display("FAIL rand_ovf a=%h b=%h bin=%b got %b want %b", a, b, bin, ov, eov); else passed++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
